// File: rtl/router_fsm_np_if.sv
// Source-side and control bundle of the 1xN router FSM.
// Carries drop_cnt and its CNT_W width only when ROUTER_FSM_STATS_EN is defined.
interface router_fsm_np_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
`ifdef ROUTER_FSM_STATS_EN
  , parameter int CNT_W   = 8
`endif
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 full_state;
  logic                 laf_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic [NUM_PORTS-1:0] dest_sel;
  logic                 drop_pkt;
`ifdef ROUTER_FSM_STATS_EN
  logic [CNT_W-1:0]     drop_cnt;
`endif

  modport master (
    output pkt_valid, data_in, fifo_empty, fifo_full, soft_reset, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
           write_enb_reg, busy, dest_sel, drop_pkt
`ifdef ROUTER_FSM_STATS_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  pkt_valid, data_in, fifo_empty, fifo_full, soft_reset, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
           write_enb_reg, busy, dest_sel, drop_pkt
`ifdef ROUTER_FSM_STATS_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/router_fsm_np.sv
// Control FSM for a 1xN packet router: header decode, load sequencing, full stalls, drops.
// Optional ROUTER_FSM_STATS_EN adds a saturating dropped-packet counter (drop_cnt).
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 0,
  parameter int TO_W         = 16
`ifdef ROUTER_FSM_STATS_EN
  , parameter int CNT_W      = 8
`endif
) (
  input  logic           clock,
  input  logic           resetn,
  router_fsm_np_if.slave bus
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  localparam bit            TIMEOUT_EN = (WAIT_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  state_t               state_reg;
  state_t               state_next;
  logic [ADDR_W-1:0]    addr_q;
  logic [TO_W-1:0]      to_cnt;
  logic                 drop_first_reg;
  logic                 drop_entry;

  logic [NUM_PORTS-1:0] live_hit;
  logic [NUM_PORTS-1:0] held_hit;
  logic                 live_valid;
  logic                 live_empty;
  logic                 held_empty;
  logic                 held_srst;

  // Address decode by comparison, so out-of-range addresses never index past the port vectors.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign live_hit[gi] = (bus.data_in == ADDR_W'(gi));
      assign held_hit[gi] = (addr_q == ADDR_W'(gi));
    end
  endgenerate

  assign live_valid = |live_hit;
  assign live_empty = |(live_hit & bus.fifo_empty);
  assign held_empty = |(held_hit & bus.fifo_empty);
  assign held_srst  = |(held_hit & bus.soft_reset);

  always_comb begin
    state_next = state_reg;
    if (state_reg != DECODE_ADDRESS && held_srst) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state_reg)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid) begin
            if (!live_valid)     state_next = DROP_PACKET;
            else if (live_empty) state_next = LOAD_FIRST_DATA;
            else                 state_next = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       state_next = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) state_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        state_next = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_next = LOAD_PARITY;
          else                        state_next = LOAD_DATA;
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (bus.fifo_full) state_next = FIFO_FULL_STATE;
          else               state_next = DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          // Empty is tested first so it wins over a coincident timeout.
          if (held_empty)                             state_next = LOAD_FIRST_DATA;
          else if (TIMEOUT_EN && to_cnt == TO_LAST)   state_next = DROP_PACKET;
        end
        DROP_PACKET: begin
          if (!bus.pkt_valid) state_next = DECODE_ADDRESS;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  assign drop_entry = (state_next == DROP_PACKET) && (state_reg != DROP_PACKET);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= DECODE_ADDRESS;
      addr_q         <= '0;
      to_cnt         <= '0;
      drop_first_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drop_first_reg <= drop_entry;
      if (state_reg == DECODE_ADDRESS && bus.pkt_valid)
        addr_q <= bus.data_in;
      // Held at zero outside the wait so every entry starts a fresh count.
      if (state_reg == WAIT_TILL_EMPTY) to_cnt <= to_cnt + TO_W'(1);
      else                              to_cnt <= '0;
    end
  end

  assign bus.detect_add    = (state_reg == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_reg == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_reg == LOAD_DATA);
  assign bus.full_state    = (state_reg == FIFO_FULL_STATE);
  assign bus.laf_state     = (state_reg == LOAD_AFTER_FULL);
  assign bus.rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_reg inside {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY});
  assign bus.busy          = !(state_reg inside {DECODE_ADDRESS, LOAD_DATA, DROP_PACKET});
  assign bus.drop_pkt      = drop_first_reg;
  assign bus.dest_sel      = (state_reg inside {LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
                                                LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR})
                             ? held_hit : '0;

`ifdef ROUTER_FSM_STATS_EN
  logic [CNT_W-1:0] drop_cnt_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      drop_cnt_reg <= '0;
    else if (drop_entry && drop_cnt_reg != {CNT_W{1'b1}})
      drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
  end

  assign bus.drop_cnt = drop_cnt_reg;
`endif

endmodule
